// File: rtl/config_chain_loader.sv
// config_chain_loader
//   Accepts parallel bitstream words over a valid/ready handshake and
//   serialises them MSB-first into the configuration flip-flop chain.
//   Exactly CHAIN_LEN bits are shifted per load; the unused low bits of
//   the final word are discarded.
//
// Ports
//   prog_clk   programming clock (only clock)
//   pReset     synchronous active-high reset
//   start      single-cycle pulse that begins a load (IDLE/DONE only)
//   abort      terminates a load in progress (LOAD/SHIFT only)
//   s_data     bitstream word, bit WORD_W-1 shifted first
//   s_valid    s_data is valid
//   s_ready    block accepts a word this cycle
//   ccff_head  serial bit to the chain head (0 when ccff_en is low)
//   ccff_en    chain shift enable
//   busy       load in progress
//   done       full chain loaded
//   error      last load was aborted
module config_chain_loader #(
  parameter int WORD_W    = 8,
  parameter int CHAIN_LEN = 1024,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              ccff_head,
  output logic              ccff_en,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int WC_W = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [WORD_W-1:0] r_sreg;
  logic [CNT_W-1:0]  r_bcnt;
  logic [WC_W-1:0]   r_wcnt;
  logic              r_error;

  // The shift that brings bcnt to CHAIN_LEN ends the load regardless of
  // how many bits are left in the current word.
  logic w_last_bit;
  logic w_last_of_word;

  assign w_last_bit     = (r_bcnt == CNT_W'(CHAIN_LEN - 1));
  assign w_last_of_word = (r_wcnt == WC_W'(1));

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      r_state <= S_IDLE;
      r_sreg  <= '0;
      r_bcnt  <= '0;
      r_wcnt  <= '0;
      r_error <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state <= S_LOAD;
            r_bcnt  <= '0;
            r_error <= 1'b0;
          end
        end
        S_LOAD: begin
          // abort wins over a handshake in the same cycle
          if (abort) begin
            r_state <= S_IDLE;
            r_error <= 1'b1;
          end else if (s_valid) begin
            r_sreg  <= s_data;
            r_wcnt  <= WC_W'(WORD_W);
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (abort) begin
            r_state <= S_IDLE;
            r_error <= 1'b1;
          end else begin
            r_sreg <= {r_sreg[WORD_W-2:0], 1'b0};
            r_bcnt <= r_bcnt + CNT_W'(1);
            r_wcnt <= r_wcnt - WC_W'(1);
            if (w_last_bit) begin
              r_state <= S_DONE;
            end else if (w_last_of_word) begin
              r_state <= S_LOAD;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode registered state; abort is the one combinational input
  // so the bit in the abort cycle never reaches the chain.
  assign s_ready   = (r_state == S_LOAD);
  assign busy      = (r_state == S_LOAD) || (r_state == S_SHIFT);
  assign done      = (r_state == S_DONE);
  assign error     = r_error;
  assign ccff_en   = (r_state == S_SHIFT) && !abort;
  assign ccff_head = ccff_en & r_sreg[WORD_W-1];

endmodule

// File: doc/config_chain_loader.md
# config_chain_loader

Loads a serial configuration bitstream into the fabric's configuration-flip-flop chain, which stores the `mem`/`mem_inv` select bits of every routing and LUT multiplexer. It accepts parallel words from a host-side source over a valid/ready handshake and serialises them MSB-first onto `ccff_head`. It qualifies each shift with `ccff_en`, stops after exactly `CHAIN_LEN` bits, and reports completion or abort. It sits between the programming interface and the head of the configuration chain in the top-level fabric wrapper.

## Interface
- `WORD_W`, default 8: width of each incoming bitstream word (≥2).
- `CHAIN_LEN`, default 1024: total number of configuration bits in the chain (≥1; need not be a multiple of `WORD_W`).
- `CNT_W`, default `$clog2(CHAIN_LEN+1)`: width of the bit counter.

Ports:
- `prog_clk`  in  1  programming clock; the only clock.
- `pReset`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle pulse that begins a load.
- `abort`  in  1  terminates an in-progress load.
- `s_data`  in  `WORD_W`  bitstream word; bit `WORD_W-1` is shifted first.
- `s_valid`  in  1  `s_data` is valid.
- `s_ready`  out  1  block accepts a word this cycle.
- `ccff_head`  out  1  serial bit to the chain head.
- `ccff_en`  out  1  chain shift enable; the chain shifts `ccff_head` in on every `prog_clk` edge where this is high.
- `busy`  out  1  load in progress (LOAD or SHIFT).
- `done`  out  1  sticky: the full chain has been loaded.
- `error`  out  1  sticky: the last load was aborted.

## Operation
- States:
  - IDLE: waits for `start`.
  - LOAD: `s_ready`=1, waits for a word.
  - SHIFT: serialises the captured word.
  - DONE: holds `done`=1.
- Registers:
  - `sreg[WORD_W]`: word shift register.
  - `bcnt[CNT_W]`: total bits shifted.
  - `wcnt`: bits remaining in the current word.
- Transitions:
  - IDLE or DONE, `start`=1: go to LOAD; `bcnt`=0; clear `done` and `error`.
  - LOAD, `s_valid && s_ready`: capture `s_data` into `sreg`; `wcnt`=`WORD_W`; go to SHIFT.
  - SHIFT, every cycle: `ccff_en`=1 and `ccff_head`=`sreg[WORD_W-1]`. Then shift `sreg` left by 1 (zero fill), `bcnt`+1, `wcnt`-1.
  - SHIFT, after the cycle that makes `bcnt`=`CHAIN_LEN`: go to DONE. Any unused low bits of that word are discarded.
  - SHIFT, otherwise after the cycle that makes `wcnt`=0: go to LOAD.
  - LOAD or SHIFT, `abort`=1: go to IDLE; `error`=1. The bit in the abort cycle is not shifted (`ccff_en`=0 that cycle). Abort has priority over a handshake or shift in the same cycle.
- `start` is ignored in LOAD and SHIFT. `abort` is ignored in IDLE and DONE.
- `ccff_head`=0 whenever `ccff_en`=0.
- `busy` = state is LOAD or SHIFT.
- `done` is high only in DONE.
- `error` holds until the next accepted `start` or reset.

## Timing
- All outputs are decoded from registered state and `sreg`; there are no combinational input-to-output paths except the abort gating of `ccff_en`.
- Reset: state=IDLE; `s_ready`, `ccff_en`, `ccff_head`, `busy`, `done`, `error` all 0; `sreg`, `bcnt`, `wcnt` all 0.
- `pReset` asserted mid-load returns the block to IDLE on the next edge with no further `ccff_en` pulses. The chain contents are then undefined.
- `start` at edge N: `s_ready`=1 in cycle N+1.
- Handshake at edge M: the first `ccff_en` is in cycle M+1. Shifting lasts `WORD_W` consecutive cycles, or fewer for the final word. `s_ready` returns in the cycle after the last shift.
- Throughput: `WORD_W`+1 cycles per word with `s_valid` held high.
- Total shift cycles per load: exactly `CHAIN_LEN`.
- `s_valid` may drop at any time in LOAD; the block waits indefinitely. `s_data` is sampled only on the handshake edge.

## Test plan
- Basic load (`WORD_W`=8, `CHAIN_LEN`=16, words 0xA5, 0x3C, `s_valid` always high) -> `ccff_head` sequence 1010010100111100 over 16 `ccff_en` cycles. `done`=1 at cycle 1+9+9; `error`=0.
- Partial last word (`CHAIN_LEN`=20, words 0xFF, 0x00, 0xB7) -> exactly 20 `ccff_en` pulses, the last 4 bits are 1011, and `s_ready` is never reasserted after the third word.
- Back-pressure: `s_valid` low for 5 cycles between words -> no `ccff_en` during the gap and an identical bit sequence; `busy` stays 1.
- Abort in the 3rd shift cycle of word 2 -> `ccff_en`=0 that cycle and after; IDLE with `error`=1, `done`=0. A subsequent `start` clears `error`.
- `start` pulsed during SHIFT and `abort` pulsed in IDLE and DONE -> no effect on state, counters or outputs.
- `pReset` during LOAD with `s_valid`=1 -> no handshake that cycle; all outputs 0 next cycle; state IDLE.
